// File: rtl/pps_stamp_capture.sv
// pps_stamp_capture: synchronises external PPS and timestamps each rising edge into a small FWFT FIFO.
// Define PPS_INTERVAL_CHECK_EN to build the PPS period sanity check that drives pps_err.
module pps_stamp_capture #(
  parameter int unsigned TIMESTAMP_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter logic [31:0] PPS_PERIOD_CYCLES = 32'h5F5E100,
  parameter int unsigned PPS_TOLERANCE     = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TIMESTAMP_WIDTH-1:0]    stamp_counter,
  input  logic                          pps_in,
  input  logic                          capture_en,
  input  logic                          clear,
  output logic [TIMESTAMP_WIDTH-1:0]    cap_tdata,
  output logic                          cap_tvalid,
  input  logic                          cap_tready,
  output logic [$clog2(FIFO_DEPTH):0]   cap_count,
  output logic [15:0]                   overflow_cnt,
  output logic                          pps_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // PPS synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic s1, s2, s3;
  logic pps_edge;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes s1->s2->s3 a shift chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pps_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pps_edge = s2 & ~s3;

  // ---------------------------------------------------------------------------
  // Capture FIFO
  // ---------------------------------------------------------------------------
  logic [TIMESTAMP_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        push_req, pop, full, push_ok, drop;

  assign push_req   = pps_edge & capture_en;
  assign cap_tvalid = (cap_count != '0);
  assign pop        = cap_tvalid & cap_tready;
  // Same slot index but opposite wrap bit means the writer has lapped the reader.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok    = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cap_count    <= '0;
      overflow_cnt <= '0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cap_count    <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE;
      if (pop)     rd_ptr <= rd_ptr + ONE;
      case ({push_ok, pop})
        2'b10:   cap_count <= cap_count + ONE;
        2'b01:   cap_count <= cap_count - ONE;
        default: cap_count <= cap_count;
      endcase
      if (drop && (overflow_cnt != 16'hFFFF)) overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  // NOTE: the storage array has no reset; its contents only matter once the
  // count says they were written, and the output gate below hides stale data.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr[AW-1:0]] <= stamp_counter;
  end

  assign cap_tdata = cap_tvalid ? mem[rd_ptr[AW-1:0]] : '0;

  // ---------------------------------------------------------------------------
  // PPS period sanity check
  // ---------------------------------------------------------------------------
`ifdef PPS_INTERVAL_CHECK_EN
  localparam logic [32:0] LOW_LIMIT  = 33'(PPS_PERIOD_CYCLES) - 33'(PPS_TOLERANCE);
  localparam logic [32:0] HIGH_LIMIT = 33'(PPS_PERIOD_CYCLES) + 33'(PPS_TOLERANCE);

  logic [31:0] interval_cnt;
  logic [32:0] elapsed;
  logic        armed;

  // The counter restarts at 0 on the edge clock, so the edge-to-edge distance is one more.
  assign elapsed = {1'b0, interval_cnt} + 33'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interval_cnt <= '0;
      armed        <= 1'b0;
      pps_err      <= 1'b0;
    end else if (clear) begin
      interval_cnt <= '0;
      armed        <= 1'b0;
      pps_err      <= 1'b0;
    end else if (pps_edge) begin
      interval_cnt <= '0;
      armed        <= 1'b1;
      if (armed && ((elapsed < LOW_LIMIT) || (elapsed > HIGH_LIMIT))) pps_err <= 1'b1;
    end else begin
      if (interval_cnt != '1) interval_cnt <= interval_cnt + 32'd1;
      // Flag a missing edge as soon as the counter passes the upper window.
      if (armed && ({1'b0, interval_cnt} > HIGH_LIMIT)) pps_err <= 1'b1;
    end
  end
`else
  assign pps_err = 1'b0;
`endif

endmodule

// File: doc/pps_stamp_capture.md
# pps_stamp_capture

Downstream consumer of the free-running stamp counter. Synchronises the external PPS input, detects its rising edge and latches the current `stamp_counter` value into a small first-word-fall-through FIFO. Software or the stats path drains the FIFO over a valid/ready interface. The block gives the host exact per-second timestamps for PPS discipline and holdover analysis, and optionally checks PPS period sanity.

## Interface
Parameters:
- `TIMESTAMP_WIDTH`, 64: width of the stamp and of captured entries.
- `FIFO_DEPTH`, 4: capture FIFO entries; power of two, ≥2.
- `PPS_PERIOD_CYCLES`, 32'h5F5E100: nominal clk cycles between PPS edges.
- `PPS_TOLERANCE`, 1000: allowed ± deviation in cycles.

Ports:
- `clk`  in  1  : the only clock.
- `reset`  in  1  : asynchronous, active-high reset.
- `stamp_counter`  in  TIMESTAMP_WIDTH  : live timestamp from the stamp counter, same clock.
- `pps_in`  in  1  : raw external PPS, asynchronous.
- `capture_en`  in  1  : when low, PPS edges are ignored.
- `clear`  in  1  : synchronous flush of the FIFO, `overflow_cnt` and `pps_err`.
- `cap_tdata`  out  TIMESTAMP_WIDTH  : head-of-FIFO timestamp.
- `cap_tvalid`  out  1  : FIFO non-empty.
- `cap_tready`  in  1  : consumer accepts the head entry.
- `cap_count`  out  log2(FIFO_DEPTH)+1  : current occupancy.
- `overflow_cnt`  out  16  : edges dropped because the FIFO was full; saturates at 16'hFFFF.
- `pps_err`  out  1  : sticky PPS period violation (see Configuration).

## Operation
- **Synchroniser.** `pps_in` passes through two flops, `s1` and `s2`, then a history flop `s3`. `pps_edge = s2 & ~s3`, a one-cycle pulse.
- **Capture.** On a clock edge where `pps_edge & capture_en`, the value of `stamp_counter` at that edge is pushed into the FIFO. No offset compensation is applied; the host subtracts the fixed synchroniser latency.
- **FIFO.** Read/write pointers are log2(FIFO_DEPTH)+1 bits wide; the extra bit disambiguates full from empty. `cap_tvalid = (count != 0)`. `cap_tdata` shows the head entry combinationally from storage. A pop occurs when `cap_tvalid & cap_tready`.
- **Full.**
  - Push while full with no pop in the same cycle: the entry is dropped and `overflow_cnt` increments, saturating.
  - Push while full with a pop in the same cycle: both happen and count is unchanged.
- **Empty.** `cap_tready` while empty has no effect. Push and pop never coincide while empty, because `cap_tvalid` is 0.
- **clear.** Has priority over push and pop in the same cycle. Pointers, count, `overflow_cnt` and `pps_err` go to 0. The synchroniser flops are not cleared.
- **capture_en low.** Edges are discarded and do not increment `overflow_cnt`. The interval logic still runs.
- **Reset.** Reset asserted mid-operation clears everything asynchronously, including the synchroniser. After reset, every output is 0: `cap_tdata`, `cap_tvalid`, `cap_count`, `overflow_cnt`, `pps_err`. Storage contents are don't-care, and `cap_tdata` is gated to 0 when the FIFO is empty.

## Timing
- `pps_in` rising before clk edge E1 results in `s1`=1 after E1 and `s2`=1 after E2. `pps_edge` is high in the cycle between E2 and E3, and the capture samples `stamp_counter` at E3.
- `cap_tvalid` rises the cycle after the capture edge, so the path from `pps_in` to `cap_tvalid` is 3 clocks.
- Pop takes effect at the accepting clock edge; the next entry or `cap_tvalid`=0 is visible the following cycle.
- `cap_count` and `overflow_cnt` are registered and update at the same edge as the push or pop.
- A PPS high for many cycles yields exactly one capture. Pulses shorter than one clk period may be missed.

## Configuration
- The macro `PPS_INTERVAL_CHECK_EN` controls the PPS period check.
- **Defined.** A 32-bit interval counter counts cycles since the last `pps_edge`, saturating at 32'hFFFFFFFF. It is reset to 0 by each edge, by `clear` and by `reset`.
  - On an edge, `pps_err` is set if the interval is less than `PPS_PERIOD_CYCLES-PPS_TOLERANCE` or greater than `PPS_PERIOD_CYCLES+PPS_TOLERANCE`.
  - `pps_err` is also set, without an edge, when the counter reaches `PPS_PERIOD_CYCLES+PPS_TOLERANCE+1`.
  - The first edge after reset or `clear` only arms the check.
  - `pps_err` stays sticky until `clear` or `reset`.
- **Undefined.** No interval counter is built and `pps_err` is tied to 0.

## Test plan
- **Single capture.** Reset, then set `stamp_counter` to increment by 28 per cycle from 0x1000. Raise `pps_in` before edge E1. Required: `cap_tdata` = the value present at E3, `cap_tvalid`=1 three clocks later, `cap_count`=1. With `cap_tready`=1, `cap_tvalid`=0 the next cycle.
- **Overflow.** `FIFO_DEPTH`=4, `cap_tready`=0, six PPS pulses. Required: `cap_count`=4, `overflow_cnt`=2, and the entries drained in order are the first four stamps.
- **Full push with pop.** FIFO full, with a PPS edge and `cap_tready`=1 in the same cycle. Required: `cap_count` stays 4, `overflow_cnt` is unchanged, and the new stamp appears as the 4th drained entry.
- **capture_en and clear.** `capture_en`=0 with two pulses: FIFO stays empty and `overflow_cnt`=0. Then pulse `clear` in the same cycle as a capture edge: all counters are 0 and no entry is stored.
- **Interval check** (`PPS_INTERVAL_CHECK_EN` defined, `PPS_PERIOD_CYCLES`=1000, `PPS_TOLERANCE`=10):
  - Edges 1000 cycles apart: `pps_err`=0.
  - Edges 1011 cycles apart: `pps_err`=1.
  - No edge for 1011 cycles after an edge: `pps_err`=1.
- **Async reset.** Assert `reset` mid-stream with 3 entries queued. Required: all outputs 0 immediately, and a pulse arriving within 2 cycles after release yields no spurious capture.
